// File: rtl/mem_wb_skid.sv
// rtl/mem_wb_skid.sv - MEM/WB pipeline register with one-entry skid buffer
// Main entry drives WB outputs directly; skid catches the input accepted while main is stalled.
module mem_wb_skid #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int RS_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_m,
  output logic             ready_m,
  input  logic             RegWriteM,
  input  logic [RS_W-1:0]  ResultSrcM,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  ReadDataM,
  input  logic [RA_W-1:0]  RdM,
  input  logic [XLEN-1:0]  PCPlus4M,
  output logic             valid_w,
  input  logic             ready_w,
  output logic             RegWriteW,
  output logic [RS_W-1:0]  ResultSrcW,
  output logic [XLEN-1:0]  ALUResultW,
  output logic [XLEN-1:0]  ReadDataW,
  output logic [RA_W-1:0]  RdW,
  output logic [XLEN-1:0]  PCPlus4W,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int EW = 1 + RS_W + 3 * XLEN + RA_W;

  logic [EW-1:0]    in_ent;
  logic [EW-1:0]    main_q, main_d;
  logic [EW-1:0]    skid_q, skid_d;
  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic             accept;
  logic             consume;
  logic             main_rw;

  // x0 is hard-wired zero, so its write enable is dropped at capture.
  assign in_ent  = {RegWriteM & (RdM != '0), ResultSrcM, ALUResultM, ReadDataM, RdM, PCPlus4M};
  assign accept  = valid_m & ready_q & ~flush;
  assign consume = main_vld_q & ready_w;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || consume) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = in_ent;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end
    ready_d  = ~skid_vld_d;
    bubble_d = bubble_q;
    if (!main_vld_q && (bubble_q != '1)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      bubble_q   <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      ready_q    <= ready_d;
      bubble_q   <= bubble_d;
    end
  end

  assign {main_rw, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W} = main_q;
  assign RegWriteW  = main_rw & main_vld_q;
  assign valid_w    = main_vld_q;
  assign ready_m    = ready_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_mem_wb_skid.sv
// tb/tb_mem_wb_skid.sv - scoreboard bench for mem_wb_skid
// Stimulus pushes expected WB entries; a forked monitor pops them on every consumed output.
module tb_mem_wb_skid;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, flush, valid_m, ready_m, ready_w, valid_w;
  logic        RegWriteM, RegWriteW;
  logic [1:0]  ResultSrcM, ResultSrcW;
  logic [31:0] ALUResultM, ALUResultW, ReadDataM, ReadDataW, PCPlus4M, PCPlus4W;
  logic [4:0]  RdM, RdW;
  logic [3:0]  bubble_cnt;

  int total = 0;
  int bad   = 0;
  ent_t exp_q[$];

  mem_wb_skid #(.XLEN(32), .RA_W(5), .RS_W(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_m(valid_m), .ready_m(ready_m),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
    .ReadDataM(ReadDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .valid_w(valid_w), .ready_w(ready_w),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Entry is driven starting now (posedge+1); returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                      input logic exp_rw);
    ent_t e;
    valid_m    = 1'b1;
    RegWriteM  = rw;
    ResultSrcM = alu[1:0];
    ALUResultM = alu;
    ReadDataM  = alu + 32'h1000;
    RdM        = rd;
    PCPlus4M   = alu + 32'h400;
    @(negedge clk);
    check("send_ready_m", 64'(ready_m), 64'd1);
    e.rw    = exp_rw;
    e.rs    = alu[1:0];
    e.alu   = alu;
    e.rdata = alu + 32'h1000;
    e.rd    = rd;
    e.pc    = alu + 32'h400;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    valid_m = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    ent_t act, e;
    reset = 1'b0; flush = 1'b0; valid_m = 1'b0; ready_w = 1'b1;
    RegWriteM = 1'b0; ResultSrcM = '0; ALUResultM = '0; ReadDataM = '0; RdM = '0; PCPlus4M = '0;

    fork
      forever begin
        @(negedge clk);
        if (reset && !flush && valid_w && ready_w) begin
          act = {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W};
          if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(ALUResultW), 64'hDEAD_0000_0000_0000);
          end else begin
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
              bad++;
              $display("FAIL wb_entry actual=rw%0d rs%0d alu%0h rd%0h rdst%0d pc%0h required=rw%0d rs%0d alu%0h rd%0h rdst%0d pc%0h",
                       act.rw, act.rs, act.alu, act.rdata, act.rd, act.pc,
                       e.rw, e.rs, e.alu, e.rdata, e.rd, e.pc);
            end
          end
        end
      end
    join_none

    // Reset state
    idle(2);
    reset = 1'b1;
    @(negedge clk);
    check("rst_valid_w", 64'(valid_w), 64'd0);
    check("rst_ready_m", 64'(ready_m), 64'd1);
    check("rst_regwrite", 64'(RegWriteW), 64'd0);
    check("rst_alu", 64'(ALUResultW), 64'd0);
    check("rst_rd", 64'(RdW), 64'd0);
    check("rst_bubble", 64'(bubble_cnt), 64'd0);
    @(posedge clk); #1;

    // Streaming: one entry per cycle, visible one cycle after accept
    ready_w = 1'b1;
    send(32'h10, 5'd3, 1'b1, 1'b1);
    check("stream_alu0", 64'(ALUResultW), 64'h10);
    check("stream_rw0", 64'(RegWriteW), 64'd1);
    send(32'h20, 5'd3, 1'b1, 1'b1);
    check("stream_alu1", 64'(ALUResultW), 64'h20);
    send(32'h30, 5'd3, 1'b1, 1'b1);
    check("stream_alu2", 64'(ALUResultW), 64'h30);
    send(32'h40, 5'd3, 1'b1, 1'b1);
    check("stream_alu3", 64'(ALUResultW), 64'h40);
    check("stream_ready", 64'(ready_m), 64'd1);
    idle(1);
    check("stream_drained", 64'(valid_w), 64'd0);

    // Backpressure: A in main, B in skid
    ready_w = 1'b0;
    send(32'hA, 5'd4, 1'b1, 1'b1);
    send(32'hB, 5'd5, 1'b0, 1'b0);
    check("bp_main_a", 64'(ALUResultW), 64'hA);
    check("bp_ready_low", 64'(ready_m), 64'd0);
    check("bp_valid", 64'(valid_w), 64'd1);
    ready_w = 1'b1;
    idle(1);
    check("bp_main_b", 64'(ALUResultW), 64'hB);
    check("bp_ready_back", 64'(ready_m), 64'd1);
    idle(1);
    check("bp_empty", 64'(valid_w), 64'd0);

    // x0 write suppression
    send(32'h55, 5'd0, 1'b1, 1'b0);
    check("x0_valid", 64'(valid_w), 64'd1);
    check("x0_rd", 64'(RdW), 64'd0);
    check("x0_regwrite", 64'(RegWriteW), 64'd0);
    idle(1);

    // Flush with both entries full and a same-edge input
    ready_w = 1'b0;
    send(32'h61, 5'd6, 1'b1, 1'b1);
    send(32'h62, 5'd7, 1'b1, 1'b1);
    valid_m = 1'b1; ALUResultM = 32'h63; RdM = 5'd8; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; valid_m = 1'b0;
    exp_q.delete();
    check("flush_valid_w", 64'(valid_w), 64'd0);
    check("flush_ready_m", 64'(ready_m), 64'd1);
    ready_w = 1'b1;
    idle(2);
    check("flush_no_ghost", 64'(valid_w), 64'd0);
    send(32'h64, 5'd9, 1'b1, 1'b1);
    check("flush_after_alu", 64'(ALUResultW), 64'h64);
    idle(1);

    // Reset mid-operation
    ready_w = 1'b0;
    send(32'h71, 5'd10, 1'b1, 1'b1);
    send(32'h72, 5'd11, 1'b1, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mrst_valid_w", 64'(valid_w), 64'd0);
    check("mrst_ready_m", 64'(ready_m), 64'd1);
    check("mrst_regwrite", 64'(RegWriteW), 64'd0);
    check("mrst_alu", 64'(ALUResultW), 64'd0);
    check("mrst_rdata", 64'(ReadDataW), 64'd0);
    check("mrst_pc", 64'(PCPlus4W), 64'd0);
    check("mrst_rs", 64'(ResultSrcW), 64'd0);
    check("mrst_rd", 64'(RdW), 64'd0);
    check("mrst_bubble", 64'(bubble_cnt), 64'd0);

    // Bubble counter saturation (CNT_W=4)
    idle(10);
    check("bubble_10", 64'(bubble_cnt), 64'd10);
    idle(10);
    check("bubble_sat", 64'(bubble_cnt), 64'd15);
    idle(3);
    check("bubble_hold", 64'(bubble_cnt), 64'd15);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
